apx_error_monitor: RTL and testbench

//  Pairs one result from the accurate float unit with one from the approximate float unit.

---
 rtl/apx_error_monitor.sv | 229 ++++++++++++++++++++++
 tb/tb_apx_error_monitor.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apx_error_monitor.sv
// apx_error_monitor: pairs one accurate and one approximate float result, measures their
// ULP distance, flags tolerance violations and keeps saturating error statistics.
module apx_error_monitor #(
    parameter int unsigned EXP_W   = 8,
    parameter int unsigned MAN_W   = 23,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned ULP_TOL = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [EXP_W+MAN_W:0] acc_z,
    input  logic                 acc_z_stb,
    output logic                 acc_z_ack,
    input  logic [EXP_W+MAN_W:0] apx_z,
    input  logic                 apx_z_stb,
    output logic                 apx_z_ack,
    input  logic                 clear,
    output logic [EXP_W+MAN_W:0] result_ulp,
    output logic                 result_mismatch,
    output logic                 result_stb,
    input  logic                 result_ack,
    output logic [CNT_W-1:0]     pair_count,
    output logic [CNT_W-1:0]     mismatch_count,
    output logic [EXP_W+MAN_W:0] max_ulp
);

    localparam int unsigned WIDTH = 1 + EXP_W + MAN_W;
    localparam int unsigned KEY_W = WIDTH + 1;
    localparam int unsigned DIF_W = WIDTH + 2;

    typedef enum logic [2:0] {
        ST_GET,
        ST_ORDER,
        ST_DIFF,
        ST_UPDATE,
        ST_PUT
    } state_t;

    state_t                   state_q, state_d;
    logic [WIDTH-1:0]         acc_q, acc_d;
    logic [WIDTH-1:0]         apx_q, apx_d;
    logic                     acc_held_q, acc_held_d;
    logic                     apx_held_q, apx_held_d;
    logic                     acc_ack_q, acc_ack_d;
    logic                     apx_ack_q, apx_ack_d;
    logic signed [KEY_W-1:0]  key_acc_q, key_acc_d;
    logic signed [KEY_W-1:0]  key_apx_q, key_apx_d;
    logic                     acc_nan_q, acc_nan_d;
    logic                     apx_nan_q, apx_nan_d;
    logic [WIDTH-1:0]         ulp_q, ulp_d;
    logic [WIDTH-1:0]         res_ulp_q, res_ulp_d;
    logic                     res_mis_q, res_mis_d;
    logic                     res_stb_q, res_stb_d;
    logic [CNT_W-1:0]         pair_cnt_q, pair_cnt_d;
    logic [CNT_W-1:0]         mis_cnt_q, mis_cnt_d;
    logic [WIDTH-1:0]         max_ulp_q, max_ulp_d;

    // Sign-magnitude to two's-complement ordering keys; +0 and -0 both land on 0.
    logic signed [KEY_W-1:0]  acc_mag_c, apx_mag_c;
    logic signed [KEY_W-1:0]  acc_key_c, apx_key_c;
    logic                     acc_nan_c, apx_nan_c;

    assign acc_mag_c = KEY_W'(acc_q[WIDTH-2:0]);
    assign apx_mag_c = KEY_W'(apx_q[WIDTH-2:0]);
    assign acc_key_c = acc_q[WIDTH-1] ? -acc_mag_c : acc_mag_c;
    assign apx_key_c = apx_q[WIDTH-1] ? -apx_mag_c : apx_mag_c;
    assign acc_nan_c = (&acc_q[WIDTH-2:MAN_W]) && (|acc_q[MAN_W-1:0]);
    assign apx_nan_c = (&apx_q[WIDTH-2:MAN_W]) && (|apx_q[MAN_W-1:0]);

    // Absolute key distance, widened so the subtraction can never overflow.
    logic signed [DIF_W-1:0]  diff_c;
    logic [DIF_W-1:0]         dist_c;
    logic [WIDTH-1:0]         ulp_c;
    logic                     ulp_over_tol_c;

    assign diff_c = DIF_W'(key_acc_q) - DIF_W'(key_apx_q);
    assign dist_c = diff_c[DIF_W-1] ? DIF_W'(-diff_c) : DIF_W'(diff_c);

    always_comb begin
        ulp_c = dist_c[WIDTH-1:0];
        if (acc_nan_q && apx_nan_q) begin
            ulp_c = '0;
        end else if (acc_nan_q || apx_nan_q) begin
            ulp_c = '1;
        end else if (|dist_c[DIF_W-1:WIDTH]) begin
            ulp_c = '1;
        end
    end

    assign ulp_over_tol_c = (ulp_q > WIDTH'(ULP_TOL));

    // Next-state and datapath control.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        apx_d      = apx_q;
        acc_held_d = acc_held_q;
        apx_held_d = apx_held_q;
        acc_ack_d  = acc_ack_q;
        apx_ack_d  = apx_ack_q;
        key_acc_d  = key_acc_q;
        key_apx_d  = key_apx_q;
        acc_nan_d  = acc_nan_q;
        apx_nan_d  = apx_nan_q;
        ulp_d      = ulp_q;
        res_ulp_d  = res_ulp_q;
        res_mis_d  = res_mis_q;
        res_stb_d  = res_stb_q;
        pair_cnt_d = pair_cnt_q;
        mis_cnt_d  = mis_cnt_q;
        max_ulp_d  = max_ulp_q;

        case (state_q)
            ST_GET: begin
                if (acc_z_stb && acc_ack_q) begin
                    acc_d      = acc_z;
                    acc_held_d = 1'b1;
                end
                if (apx_z_stb && apx_ack_q) begin
                    apx_d      = apx_z;
                    apx_held_d = 1'b1;
                end
                acc_ack_d = !acc_held_d;
                apx_ack_d = !apx_held_d;
                if (acc_held_d && apx_held_d) begin
                    state_d = ST_ORDER;
                end
            end
            ST_ORDER: begin
                key_acc_d = acc_key_c;
                key_apx_d = apx_key_c;
                acc_nan_d = acc_nan_c;
                apx_nan_d = apx_nan_c;
                state_d   = ST_DIFF;
            end
            ST_DIFF: begin
                ulp_d   = ulp_c;
                state_d = ST_UPDATE;
            end
            ST_UPDATE: begin
                res_ulp_d = ulp_q;
                res_mis_d = ulp_over_tol_c;
                res_stb_d = 1'b1;
                if (!(&pair_cnt_q)) begin
                    pair_cnt_d = pair_cnt_q + CNT_W'(1);
                end
                if (ulp_over_tol_c && !(&mis_cnt_q)) begin
                    mis_cnt_d = mis_cnt_q + CNT_W'(1);
                end
                if (ulp_q > max_ulp_q) begin
                    max_ulp_d = ulp_q;
                end
                state_d = ST_PUT;
            end
            ST_PUT: begin
                if (result_ack) begin
                    res_stb_d  = 1'b0;
                    acc_held_d = 1'b0;
                    apx_held_d = 1'b0;
                    acc_ack_d  = 1'b1;
                    apx_ack_d  = 1'b1;
                    state_d    = ST_GET;
                end
            end
            default: begin
                state_d = ST_GET;
            end
        endcase

        // Clear overrides any statistics update, including the in-flight pair.
        if (clear) begin
            pair_cnt_d = '0;
            mis_cnt_d  = '0;
            max_ulp_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_GET;
            acc_q      <= '0;
            apx_q      <= '0;
            acc_held_q <= 1'b0;
            apx_held_q <= 1'b0;
            acc_ack_q  <= 1'b0;
            apx_ack_q  <= 1'b0;
            key_acc_q  <= '0;
            key_apx_q  <= '0;
            acc_nan_q  <= 1'b0;
            apx_nan_q  <= 1'b0;
            ulp_q      <= '0;
            res_ulp_q  <= '0;
            res_mis_q  <= 1'b0;
            res_stb_q  <= 1'b0;
            pair_cnt_q <= '0;
            mis_cnt_q  <= '0;
            max_ulp_q  <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            apx_q      <= apx_d;
            acc_held_q <= acc_held_d;
            apx_held_q <= apx_held_d;
            acc_ack_q  <= acc_ack_d;
            apx_ack_q  <= apx_ack_d;
            key_acc_q  <= key_acc_d;
            key_apx_q  <= key_apx_d;
            acc_nan_q  <= acc_nan_d;
            apx_nan_q  <= apx_nan_d;
            ulp_q      <= ulp_d;
            res_ulp_q  <= res_ulp_d;
            res_mis_q  <= res_mis_d;
            res_stb_q  <= res_stb_d;
            pair_cnt_q <= pair_cnt_d;
            mis_cnt_q  <= mis_cnt_d;
            max_ulp_q  <= max_ulp_d;
        end
    end

    assign acc_z_ack       = acc_ack_q;
    assign apx_z_ack       = apx_ack_q;
    assign result_ulp      = res_ulp_q;
    assign result_mismatch = res_mis_q;
    assign result_stb      = res_stb_q;
    assign pair_count      = pair_cnt_q;
    assign mismatch_count  = mis_cnt_q;
    assign max_ulp         = max_ulp_q;

endmodule

// File: tb/tb_apx_error_monitor.sv
// Bench for apx_error_monitor: two instances (default, and CNT_W=2/ULP_TOL=1) share one
// stimulus stream and are compared against an arithmetic ULP/statistics model.
module tb_apx_error_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        result_ack;
    logic [31:0] acc_z, apx_z;
    logic        acc_z_stb, apx_z_stb;

    logic        acc_ack0, apx_ack0, res_mis0, res_stb0;
    logic [31:0] res_ulp0, max_ulp0;
    logic [15:0] pair0, mis0;
    logic        acc_ack1, apx_ack1, res_mis1, res_stb1;
    logic [31:0] res_ulp1, max_ulp1;
    logic [1:0]  pair1, mis1;

    int n_tests = 0;
    int n_fail  = 0;

    longint      cap[2] = '{65535, 3};
    longint      tol[2] = '{0, 1};
    longint      m_pair[2];
    longint      m_mis[2];
    logic [31:0] m_max[2];
    logic [31:0] m_ulp;
    string       nm[8] = '{"ulp", "mis", "stb", "pair", "miscnt", "max", "acc_ack", "apx_ack"};

    always #5 clk = ~clk;

    apx_error_monitor u_dut0 (
        .clk(clk), .rst(rst),
        .acc_z(acc_z), .acc_z_stb(acc_z_stb), .acc_z_ack(acc_ack0),
        .apx_z(apx_z), .apx_z_stb(apx_z_stb), .apx_z_ack(apx_ack0),
        .clear(clear),
        .result_ulp(res_ulp0), .result_mismatch(res_mis0), .result_stb(res_stb0),
        .result_ack(result_ack),
        .pair_count(pair0), .mismatch_count(mis0), .max_ulp(max_ulp0)
    );

    apx_error_monitor #(.CNT_W(2), .ULP_TOL(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .acc_z(acc_z), .acc_z_stb(acc_z_stb), .acc_z_ack(acc_ack1),
        .apx_z(apx_z), .apx_z_stb(apx_z_stb), .apx_z_ack(apx_ack1),
        .clear(clear),
        .result_ulp(res_ulp1), .result_mismatch(res_mis1), .result_stb(res_stb1),
        .result_ack(result_ack),
        .pair_count(pair1), .mismatch_count(mis1), .max_ulp(max_ulp1)
    );

    task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
        n_tests++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    function automatic logic [63:0] obs(input int d, input int sel);
        logic [63:0] v;
        v = '0;
        case (sel)
            0: v = (d == 0) ? 64'(res_ulp0) : 64'(res_ulp1);
            1: v = (d == 0) ? 64'(res_mis0) : 64'(res_mis1);
            2: v = (d == 0) ? 64'(res_stb0) : 64'(res_stb1);
            3: v = (d == 0) ? 64'(pair0)    : 64'(pair1);
            4: v = (d == 0) ? 64'(mis0)     : 64'(mis1);
            5: v = (d == 0) ? 64'(max_ulp0) : 64'(max_ulp1);
            6: v = (d == 0) ? 64'(acc_ack0) : 64'(acc_ack1);
            default: v = (d == 0) ? 64'(apx_ack0) : 64'(apx_ack1);
        endcase
        return v;
    endfunction

    // Handshake-visible outputs only.
    task automatic check_hs(input string ph, input bit stb, input bit aa, input bit pa);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s.d%0d.%s", ph, d, nm[2]), obs(d, 2), 64'(stb));
            check($sformatf("%s.d%0d.%s", ph, d, nm[6]), obs(d, 6), 64'(aa));
            check($sformatf("%s.d%0d.%s", ph, d, nm[7]), obs(d, 7), 64'(pa));
        end
    endtask

    task automatic check_all(input string ph, input bit stb, input bit aa, input bit pa);
        logic [63:0] e;
        check_hs(ph, stb, aa, pa);
        for (int d = 0; d < 2; d++) begin
            for (int s = 0; s < 6; s++) begin
                case (s)
                    0: e = 64'(m_ulp);
                    1: e = (longint'(m_ulp) > tol[d]) ? 64'd1 : 64'd0;
                    3: e = 64'(m_pair[d]);
                    4: e = 64'(m_mis[d]);
                    5: e = 64'(m_max[d]);
                    default: e = '0;
                endcase
                if (s != 2) check($sformatf("%s.d%0d.%s", ph, d, nm[s]), obs(d, s), e);
            end
        end
    endtask

    function automatic logic [31:0] ref_ulp(input logic [31:0] a, input logic [31:0] b);
        bit     na, nb;
        longint ka, kb, dd;
        na = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        nb = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        if (na && nb) return 32'd0;
        if (na || nb) return 32'hFFFF_FFFF;
        ka = a[31] ? -longint'(a[30:0]) : longint'(a[30:0]);
        kb = b[31] ? -longint'(b[30:0]) : longint'(b[30:0]);
        dd = ka - kb;
        if (dd < 0) dd = -dd;
        return 32'(dd);
    endfunction

    task automatic model_zero();
        m_ulp = '0;
        for (int d = 0; d < 2; d++) begin
            m_pair[d] = 0;
            m_mis[d]  = 0;
            m_max[d]  = '0;
        end
    endtask

    task automatic model_pair(input logic [31:0] a, input logic [31:0] b, input bit clr);
        m_ulp = ref_ulp(a, b);
        for (int d = 0; d < 2; d++) begin
            if (clr) begin
                m_pair[d] = 0;
                m_mis[d]  = 0;
                m_max[d]  = '0;
            end else begin
                if (m_pair[d] < cap[d]) m_pair[d]++;
                if (longint'(m_ulp) > tol[d] && m_mis[d] < cap[d]) m_mis[d]++;
                if (m_ulp > m_max[d]) m_max[d] = m_ulp;
            end
        end
    endtask

    // One pair: operands raised da/db cycles in, result held unacked for ack_wait cycles.
    task automatic do_pair(input logic [31:0] a, input logic [31:0] b, input int da,
                           input int db, input int ack_wait, input bit clr_upd);
        int c, lat;
        bit ad, bd, af, bf;
        ad = 0; bd = 0; c = 0;
        acc_z = a;
        apx_z = b;
        while (!(ad && bd)) begin
            acc_z_stb = !ad && (c >= da);
            apx_z_stb = !bd && (c >= db);
            af = acc_z_stb && acc_ack0;
            bf = apx_z_stb && apx_ack0;
            @(posedge clk); #1;
            c++;
            if (af) ad = 1;
            if (bf) bd = 1;
            if (c > 200) begin
                n_tests++;
                n_fail++;
                $display("FAIL capture_timeout acc_done=%0d apx_done=%0d required=1/1", ad, bd);
                acc_z_stb = 0;
                apx_z_stb = 0;
                return;
            end
            if (!(ad && bd)) check_hs("wait", 0, !ad, !bd);
        end
        acc_z_stb = 0;
        apx_z_stb = 0;
        check_hs("captured", 0, 0, 0);
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            if (clr_upd && lat == 2) clear = 1;
            @(posedge clk); #1;
            clear = 0;
            lat++;
            if (res_stb0) break;
            check_hs("busy", 0, 0, 0);
        end
        check("latency", 64'(lat), 64'd3);
        model_pair(a, b, clr_upd);
        check_all("result", 1, 0, 0);
        for (int i = 0; i < ack_wait; i++) begin
            @(posedge clk); #1;
            check_all("hold", 1, 0, 0);
        end
        result_ack = 1;
        @(posedge clk); #1;
        result_ack = 0;
        check_hs("acked", 0, 1, 1);
    endtask

    // Pair aborted by a reset pulse while the monitor is in DIFF.
    task automatic do_rst_in_diff(input logic [31:0] a, input logic [31:0] b);
        acc_z = a; apx_z = b;
        acc_z_stb = 1; apx_z_stb = 1;
        @(posedge clk); #1;
        acc_z_stb = 0; apx_z_stb = 0;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        model_zero();
        check_all("rst_diff", 0, 0, 0);
        rst = 0;
        @(posedge clk); #1;
        check_hs("rst_release", 0, 1, 1);
    endtask

    function automatic logic [31:0] rnd_val(input logic [31:0] base);
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0: v = $urandom;
            1: v = base ^ 32'($urandom_range(0, 7));
            2: v = 32'h7FC0_0000 | 32'($urandom_range(1, 1000));
            3: v = base[31] ? 32'hFF80_0000 : 32'h7F80_0000;
            4: v = $urandom_range(0, 1) ? 32'h8000_0000 : 32'h0000_0000;
            default: v = base;
        endcase
        return v;
    endfunction

    initial begin
        logic [31:0] a, b;
        rst = 1; clear = 0; result_ack = 0;
        acc_z = '0; apx_z = '0; acc_z_stb = 0; apx_z_stb = 0;
        model_zero();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 0, 0, 0);
        rst = 0;
        @(posedge clk); #1;
        check_hs("post_reset", 0, 1, 1);

        do_pair(32'h4040_0000, 32'h4040_0000, 0, 0, 0, 0);
        do_pair(32'h3F80_0000, 32'h3F80_0001, 0, 0, 0, 0);
        do_pair(32'h0000_0000, 32'h8000_0000, 0, 1, 0, 0);
        do_pair(32'h0000_0001, 32'h8000_0001, 2, 0, 0, 0);
        do_pair(32'h7FC0_0000, 32'h3F80_0000, 0, 0, 1, 0);
        do_pair(32'h7FC0_0001, 32'hFFC0_0000, 0, 0, 0, 0);
        do_pair(32'h7F80_0000, 32'hFF80_0000, 0, 0, 0, 0);

        do_pair(32'h4120_0000, 32'h4120_0003, 0, 7, 0, 0);
        do_pair(32'hC120_0000, 32'hC120_0002, 7, 0, 0, 0);
        do_pair(32'h3F00_0000, 32'h3F00_0000, 3, 3, 0, 0);

        for (int i = 0; i < 5; i++) do_pair(32'h3F80_0000, 32'h3F80_0005, 0, 0, 0, 0);
        do_pair(32'h3F80_0000, 32'h3F80_0009, 0, 0, 0, 1);
        do_pair(32'h4000_0000, 32'h4000_0004, 1, 0, 20, 0);
        do_rst_in_diff(32'h3F80_0000, 32'hBF80_0000);
        do_pair(32'h3F80_0000, 32'hBF80_0000, 0, 0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = rnd_val(a);
            if ($urandom_range(0, 7) == 0) a = rnd_val(b);
            do_pair(a, b, $urandom_range(0, 4), $urandom_range(0, 4),
                    $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
